// File: rtl/fpu_result_fifo_if.sv
`default_nettype none
// ============================================================================
// Module      : fpu_result_fifo_if
// Description : Bundle of the FPU-side capture handshake and the host-side
//               read/status signals of fpu_result_fifo.
//               slave  : the FIFO (consumes FPU/host controls, drives status)
//               master : the environment driving the FIFO
// Ports       : fpu_doorbell_r_i, fpu_ready, fpu_output[31:0],
//               fpu_output_flags[3:0], fpu_interrupt_w, int_en, clr_ovf,
//               rd_en, rd_data[31:0], rd_flags[3:0], rd_tstamp[15:0],
//               empty, full, count[AW:0], overflow, irq
// Revision    : 1.0 - initial release
// ============================================================================
interface fpu_result_fifo_if #(
    parameter int AW = 3
);
    // FPU output register side
    logic          fpu_doorbell_r_i;
    logic          fpu_ready;
    logic [31:0]   fpu_output;
    logic [3:0]    fpu_output_flags;
    logic          fpu_interrupt_w;

    // Host side
    logic          int_en;
    logic          clr_ovf;
    logic          rd_en;
    logic [31:0]   rd_data;
    logic [3:0]    rd_flags;
    logic [15:0]   rd_tstamp;
    logic          empty;
    logic          full;
    logic [AW:0]   count;
    logic          overflow;
    logic          irq;

    modport slave (
        input  fpu_doorbell_r_i, fpu_ready, fpu_output, fpu_output_flags,
        input  int_en, clr_ovf, rd_en,
        output fpu_interrupt_w, rd_data, rd_flags, rd_tstamp,
        output empty, full, count, overflow, irq
    );

    modport master (
        output fpu_doorbell_r_i, fpu_ready, fpu_output, fpu_output_flags,
        output int_en, clr_ovf, rd_en,
        input  fpu_interrupt_w, rd_data, rd_flags, rd_tstamp,
        input  empty, full, count, overflow, irq
    );
endinterface
`default_nettype wire

// File: rtl/fpu_result_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fpu_result_fifo
// Description : Buffers {flags,result} pairs from the FPU output register so
//               host reads are decoupled from the FPU issue rate. A result is
//               snapshotted one cycle after the doorbell into a staging
//               register and pushed into the FIFO as soon as a slot is free;
//               fpu_interrupt_w holds the output register while a staged
//               result is waiting. A registered level interrupt asserts when
//               the fill level reaches IRQ_THRESH.
// Ports       : clk, reset (sync, active-high)
//               bus (fpu_result_fifo_if.slave): doorbell/result/flags in,
//               fpu_interrupt_w out, host rd_en/int_en/clr_ovf in,
//               show-ahead rd_data/rd_flags/rd_tstamp, empty/full/count,
//               overflow (sticky), irq
// Options     : FPU_RESULT_TIMESTAMP_EN - adds a 16-bit free-running cycle
//               counter sampled with each snapshot and stored per entry.
// Revision    : 1.0 - initial release
// ============================================================================
module fpu_result_fifo #(
    parameter int DEPTH      = 8,
    parameter int AW         = 3,
    parameter int IRQ_THRESH = 1
) (
    input  wire logic          clk,
    input  wire logic          reset,
    fpu_result_fifo_if.slave   bus
);

    localparam logic [AW:0] c_depth  = (AW+1)'(DEPTH);
    localparam logic [AW:0] c_thresh = (AW+1)'(IRQ_THRESH);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_PEND = 1'b1
    } state_t;

    state_t        r_state;
    state_t        w_state_next;

    logic          r_db_d;
    logic [31:0]   r_stage_data;
    logic [3:0]    r_stage_flags;

    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic [AW:0]   w_count_next;
    logic          r_overflow;
    logic          r_irq;

    logic [31:0]   r_mem_data  [DEPTH];
    logic [3:0]    r_mem_flags [DEPTH];

    logic          w_empty;
    logic          w_full;
    logic          w_pop;
    logic          w_push;
    logic          w_ovf_set;

    // The output register's ready is not needed: capture is gated by the
    // staging state alone.
    logic          w_unused_ready;
    assign w_unused_ready = bus.fpu_ready;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == c_depth);
    assign w_pop   = bus.rd_en && !w_empty;

    // ------------------------------------------------------------------------
    // Capture FSM: next state, push and overflow decisions
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_push       = 1'b0;
        w_ovf_set    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_db_d) begin
                    w_state_next = ST_PEND;
                end
            end
            ST_PEND: begin
                // A pop in the same cycle frees the slot even when full.
                w_push = !w_full || w_pop;
                if (r_db_d) begin
                    // New snapshot replaces staging; it is only lost data
                    // when the old entry could not be pushed out first.
                    w_state_next = ST_PEND;
                    w_ovf_set    = !w_push;
                end else if (w_push) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + 1'b1;
            2'b01:   w_count_next = r_count - 1'b1;
            default: w_count_next = r_count;
        endcase
    end

    // ------------------------------------------------------------------------
    // Control state
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_db_d        <= 1'b0;
            r_stage_data  <= '0;
            r_stage_flags <= '0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_overflow    <= 1'b0;
            r_irq         <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_db_d  <= bus.fpu_doorbell_r_i;
            if (r_db_d) begin
                r_stage_data  <= bus.fpu_output;
                r_stage_flags <= bus.fpu_output_flags;
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= w_count_next;
            // Set has priority over a simultaneous clear.
            if (w_ovf_set) begin
                r_overflow <= 1'b1;
            end else if (bus.clr_ovf) begin
                r_overflow <= 1'b0;
            end
            r_irq <= bus.int_en && (w_count_next >= c_thresh);
        end
    end

    // Storage array is intentionally not reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_data[r_wr_ptr]  <= r_stage_data;
            r_mem_flags[r_wr_ptr] <= r_stage_flags;
        end
    end

`ifdef FPU_RESULT_TIMESTAMP_EN
    logic [15:0] r_cycle;
    logic [15:0] r_stage_ts;
    logic [15:0] r_mem_ts [DEPTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cycle    <= '0;
            r_stage_ts <= '0;
        end else begin
            r_cycle <= r_cycle + 1'b1;
            if (r_db_d) begin
                r_stage_ts <= r_cycle;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_ts[r_wr_ptr] <= r_stage_ts;
        end
    end

    assign bus.rd_tstamp = w_empty ? 16'h0000 : r_mem_ts[r_rd_ptr];
`else
    assign bus.rd_tstamp = 16'h0000;
`endif

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign bus.rd_data         = w_empty ? 32'h0 : r_mem_data[r_rd_ptr];
    assign bus.rd_flags        = w_empty ? 4'h0  : r_mem_flags[r_rd_ptr];
    assign bus.empty           = w_empty;
    assign bus.full            = w_full;
    assign bus.count           = r_count;
    assign bus.overflow        = r_overflow;
    assign bus.irq             = r_irq;
    assign bus.fpu_interrupt_w = (r_state == ST_PEND);

endmodule
`default_nettype wire

// File: tb/tb_fpu_result_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_fpu_result_fifo
// Description : Self-checking bench for fpu_result_fifo (DEPTH=8,
//               IRQ_THRESH=1). Results rung in are queued in a scoreboard
//               and compared when popped; a vector table drives the
//               wrap-around sequence; hand sequences cover capture latency,
//               full/overflow, push+pop at full, timestamps and reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fpu_result_fifo;

    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic clk;
    logic reset;

    fpu_result_fifo_if #(.AW(AW)) bus ();

    fpu_result_fifo #(
        .DEPTH      (DEPTH),
        .AW         (AW),
        .IRQ_THRESH (1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] in_data;
        logic [3:0]  in_flags;
        logic [31:0] exp_data;
        logic [3:0]  exp_flags;
    } vec_t;

    typedef struct {
        logic [31:0] d;
        logic [3:0]  f;
    } sb_t;

    vec_t vecs [20];
    sb_t  sb_q [$];
    int   n_vec  = 0;
    int   n_fail = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Doorbell pulse for one edge; optionally record the result as expected.
    task automatic ring(input logic [31:0] d, input logic [3:0] f, input bit expect_it);
        bus.fpu_output       = d;
        bus.fpu_output_flags = f;
        bus.fpu_doorbell_r_i = 1'b1;
        tick();
        bus.fpu_doorbell_r_i = 1'b0;
        if (expect_it) begin
            sb_q.push_back('{d: d, f: f});
        end
    endtask

    // Compare the head against the scoreboard, then pop it.
    task automatic pop_check(input string name);
        sb_t e;
        if (sb_q.size() == 0) begin
            n_vec++;
            n_fail++;
            $display("FAIL %s: scoreboard empty, got rd_data %0h", name, bus.rd_data);
        end else begin
            e = sb_q.pop_front();
            check({name, "_data"},  bus.rd_data,  e.d);
            check({name, "_flags"}, bus.rd_flags, e.f);
        end
        bus.rd_en = 1'b1;
        tick();
        bus.rd_en = 1'b0;
    endtask

    initial begin
        logic [15:0] ts_a;
        logic [15:0] ts_b;

        bus.fpu_doorbell_r_i = 1'b0;
        bus.fpu_ready        = 1'b1;
        bus.fpu_output       = '0;
        bus.fpu_output_flags = '0;
        bus.int_en           = 1'b0;
        bus.clr_ovf          = 1'b0;
        bus.rd_en            = 1'b0;

        for (int i = 0; i < 20; i++) begin
            vecs[i].in_data   = 32'(i + 1);
            vecs[i].in_flags  = 4'(i);
            vecs[i].exp_data  = 32'(i + 1);
            vecs[i].exp_flags = 4'(i);
        end

        // ---------------- reset ----------------
        reset = 1'b1;
        tick();
        tick();
        check("rst_empty",    bus.empty, 1);
        check("rst_full",     bus.full, 0);
        check("rst_count",    bus.count, 0);
        check("rst_irq",      bus.irq, 0);
        check("rst_hold",     bus.fpu_interrupt_w, 0);
        check("rst_overflow", bus.overflow, 0);
        check("rst_rd_data",  bus.rd_data, 0);
        reset = 1'b0;

        // ---------------- single capture ----------------
        bus.int_en = 1'b1;
        ring(32'h3F80_0000, 4'b0001, 1);
        tick();
        check("cap_hold_1",  bus.fpu_interrupt_w, 1);
        check("cap_count_0", bus.count, 0);
        tick();
        check("cap_hold_0",  bus.fpu_interrupt_w, 0);
        check("cap_count_1", bus.count, 1);
        tick();
        check("cap_irq",     bus.irq, 1);
        check("cap_tstamp0", bus.rd_tstamp, 0);
        pop_check("cap_pop");
        check("cap_empty",   bus.empty, 1);
        check("cap_irq_off", bus.irq, 0);

        // ---------------- timestamps ----------------
        ring(32'hAAAA_0001, 4'h2, 1);
        for (int i = 0; i < 4; i++) tick();
        ring(32'hAAAA_0002, 4'h3, 1);
        tick();
        tick();
        tick();
        check("ts_count", bus.count, 2);
        ts_a = bus.rd_tstamp;
        pop_check("ts_pop_a");
        ts_b = bus.rd_tstamp;
`ifdef FPU_RESULT_TIMESTAMP_EN
        check("ts_delta", 16'(ts_b - ts_a), 5);
`else
        check("ts_a_zero", ts_a, 0);
        check("ts_b_zero", ts_b, 0);
`endif
        pop_check("ts_pop_b");

        // ---------------- fill to full, overflow, push+pop at full ----------------
        bus.int_en = 1'b0;
        for (int i = 1; i <= DEPTH; i++) begin
            ring(32'(i), 4'(i), 1);
            tick();
            tick();
        end
        check("fill_count", bus.count, 8);
        check("fill_full",  bus.full, 1);
        check("fill_irq_disabled", bus.irq, 0);
        bus.int_en = 1'b1;
        tick();
        check("fill_irq_enabled", bus.irq, 1);
        ring(32'd9, 4'd9, 0);
        tick();
        check("full_hold_a", bus.fpu_interrupt_w, 1);
        tick();
        check("full_hold_b", bus.fpu_interrupt_w, 1);
        check("full_no_ovf", bus.overflow, 0);
        ring(32'd10, 4'd10, 1);
        tick();
        check("ovf_set",     bus.overflow, 1);
        check("ovf_hold",    bus.fpu_interrupt_w, 1);
        check("ovf_count",   bus.count, 8);
        pop_check("pp_pop");
        check("pp_count",    bus.count, 8);
        check("pp_hold",     bus.fpu_interrupt_w, 0);
        check("pp_full",     bus.full, 1);
        for (int i = 0; i < DEPTH; i++) pop_check("drain");
        check("drain_empty", bus.empty, 1);
        check("drain_sb",    sb_q.size(), 0);
        bus.clr_ovf = 1'b1;
        tick();
        bus.clr_ovf = 1'b0;
        check("ovf_clear",   bus.overflow, 0);

        // ---------------- wrap via vector table ----------------
        for (int i = 0; i < 20; i++) begin
            ring(vecs[i].in_data, vecs[i].in_flags, 1);
            tick();
            tick();
            check("vec_data",  bus.rd_data,  vecs[i].exp_data);
            check("vec_flags", bus.rd_flags, vecs[i].exp_flags);
            pop_check("wrap_pop");
        end
        bus.rd_en = 1'b1;
        tick();
        bus.rd_en = 1'b0;
        check("rd_empty_count", bus.count, 0);
        check("rd_empty_flag",  bus.empty, 1);
        check("rd_empty_data",  bus.rd_data, 0);

        // ---------------- reset mid-operation ----------------
        ring(32'h55, 4'h5, 0);
        tick();
        tick();
        ring(32'h66, 4'h6, 0);
        tick();
        check("mid_pending", bus.fpu_interrupt_w, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_count", bus.count, 0);
        check("mid_empty", bus.empty, 1);
        check("mid_hold",  bus.fpu_interrupt_w, 0);
        tick();
        tick();
        check("mid_discard", bus.count, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
